io_out_fifo: RTL
================

# io_out_fifo

Output-port buffer sitting directly downstream of the floating-point processor core. It captures every core output write (`out_en` with `addr_out` and `data_out`) into a tagged FIFO and presents the entries to external consumers through a valid/ready handshake. The core has no backpressure, so the block absorbs output bursts, drops writes on overflow and flags every drop.

## Interface
- `NBMANT`, 16: mantissa bits of the core data word.
- `NBEXPO`, 6: exponent bits; data word width is `NBW = NBMANT+NBEXPO+1`.
- `NUIOOU`, 8: number of output port addresses; tag width is `NBA = $clog2(NUIOOU)`.
- `FDEPTH`, 8: FIFO entries; must be a power of 2 and ≥2.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `out_en`, in, 1: core output write strobe.
- `addr_out`, in, NBA: core output port address.
- `data_in`, in, NBW: core output data (core `data_out`).
- `m_valid`, out, 1: head entry available.
- `m_ready`, in, 1: consumer accepts head entry.
- `m_addr`, out, NBA: port tag of head entry.
- `m_data`, out, NBW: data of head entry.
- `full`, out, 1: count == FDEPTH.
- `empty`, out, 1: count == 0.
- `count`, out, $clog2(FDEPTH)+1: current occupancy.
- `ovf`, out, 1: sticky overflow flag.
- `ovf_clr`, in, 1: clears `ovf`.

## Operation
- Entry = {addr_out, data_in}, NBA+NBW bits; storage is circular, with wr_ptr and rd_ptr of $clog2(FDEPTH) bits that wrap modulo FDEPTH.
- pop = m_valid && m_ready. push_req = out_en.
- Accept push if count < FDEPTH, or if count == FDEPTH and pop in the same cycle (the freed slot is reused).
- Rejected push: data is dropped, pointers and count are unchanged, and `ovf` is set.
- count_next = count + accepted_push − pop. Simultaneous accepted push and pop leaves count unchanged and both pointers advance.
- Pop when empty is impossible (m_valid=0); m_ready is ignored.
- Show-ahead: m_addr/m_data always reflect mem[rd_ptr]. Their value when empty is don't-care but must not be X after reset (memory is not reset; the outputs are muxed to 0 when empty).
- `ovf`: set on a rejected push, cleared by `ovf_clr`. A same-cycle set and clear results in set.
- No state machine beyond pointer/count; the block is a pure FIFO datapath. Data is not interpreted (no float handling).

## Timing
- Reset values: m_valid=0, m_addr=0, m_data=0, full=0, empty=1, count=0, ovf=0, wr_ptr=rd_ptr=0.
- Write latency: out_en sampled at edge k means the entry is visible (m_valid=1 if previously empty) after edge k, i.e. in cycle k+1.
- Pop: head is consumed at the edge where m_valid&&m_ready; the next entry appears in the following cycle. Full throughput is 1 entry/cycle with m_ready held high.
- full, empty, count and m_valid are registered/derived from registered count; no combinational path from out_en to any output.
- m_ready → outputs: no combinational path.
- Reset mid-operation: all contents are discarded immediately (asynchronous); pending entries are lost, ovf is cleared.

## Structure
- Shared package `io_out_pkg`: localparams NBW, NBA and the entry width, plus a helper function for ptr increment with wrap.
- Sub-module `io_fifo_mem`: a simple dual-port register array (one write port, one asynchronous read port), parameterised by width and depth, with no reset on storage.
- The top holds the pointers, count, ovf logic and output muxing.

## Test plan
- Reset then single write: out_en=1, addr_out=3, data_in=23'h1A5A5A. Expect m_valid=1, m_addr=3, m_data=23'h1A5A5A in the next cycle and count=1. After m_ready=1 for one cycle, expect empty=1.
- Fill to FDEPTH=8 with m_ready=0, using data 1..8. Expect full=1 and count=8. Drain with m_ready=1 and check order 1..8 with one entry per cycle.
- Overflow: while full, write data 9 with no pop. Expect 9 dropped, count=8, ovf=1. Pulse ovf_clr: ovf=0. Assert ovf_clr and a rejected write in the same cycle: ovf stays 1.
- Full with simultaneous pop and push (data 10): push accepted, count stays 8, and 10 emerges last.
- Wrap-around: 20 cycles of continuous out_en with m_ready=1 and an incrementing data pattern. Expect an in-order stream, count ≤1, ovf=0.
- Reset asserted asynchronously with count=5: expect all outputs back at their reset values before the next clock edge.

Source files
------------

// File: rtl/io_out_pkg.sv
// Shared definitions for the core output-port FIFO.
// Holds the default core word geometry, derived widths for that default
// configuration, and a pointer-increment helper that wraps at the FIFO depth.
package io_out_pkg;

  localparam int unsigned NBMANT_DEF = 16;
  localparam int unsigned NBEXPO_DEF = 6;
  localparam int unsigned NUIOOU_DEF = 8;
  localparam int unsigned FDEPTH_DEF = 8;

  localparam int unsigned NBW     = NBMANT_DEF + NBEXPO_DEF + 1;
  localparam int unsigned NBA     = $clog2(NUIOOU_DEF);
  localparam int unsigned ENTRY_W = NBA + NBW;

  // Next circular-buffer index; wraps to 0 after depth-1.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 32'd1 == depth) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/io_fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one
// asynchronous read port. Storage is deliberately not reset.
// Ports:
//   clk      - write clock
//   we_i     - write enable
//   waddr_i  - write index
//   wdata_i  - write data
//   raddr_i  - read index
//   rdata_o  - combinational read data at raddr_i
module io_fifo_mem #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/io_out_fifo.sv
// Output-port buffer behind the floating-point core. Every core output write
// (out_en with addr_out/data_in) is captured as a tagged entry and presented
// show-ahead on a valid/ready interface. The core cannot be stalled, so writes
// arriving while full are dropped and flagged in the sticky ovf bit.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   out_en/addr_out/data_in - core output write strobe, port tag, data word
//   m_valid/m_ready      - head entry handshake
//   m_addr/m_data        - head entry tag and data (0 when empty)
//   full/empty/count     - occupancy status, all from registered count
//   ovf/ovf_clr          - sticky drop flag and its clear
module io_out_fifo
  import io_out_pkg::*;
#(
  parameter int unsigned NBMANT = NBMANT_DEF,
  parameter int unsigned NBEXPO = NBEXPO_DEF,
  parameter int unsigned NUIOOU = NUIOOU_DEF,
  parameter int unsigned FDEPTH = FDEPTH_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 out_en,
  input  logic [$clog2(NUIOOU)-1:0]            addr_out,
  input  logic [NBMANT+NBEXPO:0]               data_in,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [$clog2(NUIOOU)-1:0]            m_addr,
  output logic [NBMANT+NBEXPO:0]               m_data,
  output logic                                 full,
  output logic                                 empty,
  output logic [$clog2(FDEPTH):0]              count,
  output logic                                 ovf,
  input  logic                                 ovf_clr
);

  localparam int unsigned DW = NBMANT + NBEXPO + 1;
  localparam int unsigned AW = $clog2(NUIOOU);
  localparam int unsigned EW = AW + DW;
  localparam int unsigned PW = $clog2(FDEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          pop;
  logic          push_ok;
  logic [EW-1:0] head;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FDEPTH));
  assign m_valid = !empty;
  assign count   = count_q;
  assign ovf     = ovf_q;

  assign pop     = m_valid && m_ready;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign push_ok = out_en && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    if (push_ok) begin
      wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), FDEPTH));
    end
    if (pop) begin
      rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), FDEPTH));
    end
    // Set wins over clear so a drop is never lost.
    if (out_en && !push_ok) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  io_fifo_mem #(
    .Width (EW),
    .Depth (FDEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i ({addr_out, data_in}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // Unwritten storage may be X; hide it while empty.
  assign m_addr = empty ? '0 : head[EW-1:DW];
  assign m_data = empty ? '0 : head[DW-1:0];

endmodule
